// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
package disp_pkg;

    typedef enum logic {
        DRIVE = 1'b0,
        GUARD = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Active-low glyphs, segment a in bit 6 down to g in bit 0; element 0 is rightmost.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1111111,  // F (blank)
        7'b1111111,  // E (blank)
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    // A digit is a leading zero when it and every more-significant nibble are 0; digit 0 always shows.
    function automatic logic lz_blank(input logic [15:0] disp, input logic [1:0] idx);
        logic blank;
        case (idx)
            2'd3:    blank = (disp[15:12] == 4'h0);
            2'd2:    blank = (disp[15:8] == 8'h00);
            2'd1:    blank = (disp[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/display_bin_hex.sv
// Combinational nibble to active-low seven-segment decoder.
module display_bin_hex
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup of the glyph for the selected nibble.
    always_comb begin
        seg_o = SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with frame-synchronous data update
// and optional leading-zero blanking.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 27000,
    parameter int unsigned GUARD_TICKS = 270
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] data_i,
    input  logic        blank_lz_i,
    output logic [6:0]  seven,
    output logic [3:0]  anodo,
    output logic        pending_o,
    output logic        frame_o
);

    localparam int unsigned MAX_TICKS = (DIGIT_TICKS > GUARD_TICKS) ? DIGIT_TICKS : GUARD_TICKS;
    localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_TICKS - 1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      stage_q, stage_d;
    logic             pend_q, pend_d;
    logic [6:0]       seven_q, seven_d;
    logic [3:0]       anodo_q, anodo_d;
    logic             frame_q, frame_d;
    logic             boundary;
    logic [3:0]       nib;
    logic [6:0]       seg;

    // Phase sequencer: DRIVE/GUARD tick counting and digit advance; flags the frame boundary.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tick_d   = tick_q + CNT_W'(1);
        boundary = 1'b0;
        case (state_q)
            DRIVE: begin
                if (tick_q == DRIVE_LAST) begin
                    state_d = GUARD;
                    tick_d  = '0;
                end
            end
            GUARD: begin
                if (tick_q == GUARD_LAST) begin
                    state_d  = DRIVE;
                    tick_d   = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end
            end
        endcase
    end

    // Staging and display update; a load on the boundary cycle re-arms pending after the swap.
    always_comb begin
        disp_d  = disp_q;
        stage_d = stage_q;
        pend_d  = pend_q;
        if (boundary) begin
            if (pend_q) begin
                disp_d = stage_q;
            end
            pend_d = 1'b0;
        end
        if (load_i) begin
            stage_d = data_i;
            pend_d  = 1'b1;
        end
    end

    // Nibble mux feeding the single shared decoder.
    always_comb begin
        case (idx_q)
            2'd0:    nib = disp_q[3:0];
            2'd1:    nib = disp_q[7:4];
            2'd2:    nib = disp_q[11:8];
            default: nib = disp_q[15:12];
        endcase
    end

    display_bin_hex u_hex (
        .nibble_i (nib),
        .seg_o    (seg)
    );

    // Next output values derived from the current phase, digit and blanking request.
    always_comb begin
        seven_d = SEG_OFF;
        anodo_d = ANODE_OFF;
        frame_d = boundary;
        if ((state_q == DRIVE) && !(blank_lz_i && lz_blank(disp_q, idx_q))) begin
            seven_d = seg;
            anodo_d = ~(4'b0001 << idx_q);
        end
    end

    // State and output registers; reset parks in the last GUARD so a boundary follows shortly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GUARD;
            idx_q   <= 2'd3;
            tick_q  <= '0;
            disp_q  <= '0;
            stage_q <= '0;
            pend_q  <= 1'b0;
            seven_q <= SEG_OFF;
            anodo_q <= ANODE_OFF;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            disp_q  <= disp_d;
            stage_q <= stage_d;
            pend_q  <= pend_d;
            seven_q <= seven_d;
            anodo_q <= anodo_d;
            frame_q <= frame_d;
        end
    end

    assign seven     = seven_q;
    assign anodo     = anodo_q;
    assign pending_o = pend_q;
    assign frame_o   = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a 4-cycle drive / 2-cycle guard scan.
module tb_display_scan_ctrl;

    localparam int unsigned DT = 4;
    localparam int unsigned GT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_i;
    logic [15:0] data_i;
    logic        blank_lz_i;
    logic [6:0]  seven;
    logic [3:0]  anodo;
    logic        pending_o;
    logic        frame_o;

    int n_chk = 0;
    int n_bad = 0;

    logic [15:0] m_disp;
    logic [15:0] m_stage;
    logic        m_pend;

    display_scan_ctrl #(
        .DIGIT_TICKS (DT),
        .GUARD_TICKS (GT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_i),
        .data_i     (data_i),
        .blank_lz_i (blank_lz_i),
        .seven      (seven),
        .anodo      (anodo),
        .pending_o  (pending_o),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // Runs one 24-cycle frame starting just after a boundary edge; up to three loads (slot 0 = none).
    task automatic run_frame(input string name, input logic lz,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input int lc, input logic [15:0] vc);
        logic        loaded;
        logic [15:0] lval;
        logic [15:0] shown;
        logic [3:0]  nib;
        logic        blank;
        logic [3:0]  exp_an;
        logic [6:0]  exp_sv;
        int          pos, d, ph;
        shown      = m_disp;
        loaded     = 1'b0;
        lval       = '0;
        blank_lz_i = lz;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            if (j == 24) begin
                if (m_pend) m_disp = m_stage;
                m_pend = 1'b0;
            end
            if (loaded) begin
                m_stage = lval;
                m_pend  = 1'b1;
            end
            pos    = j - 1;
            d      = pos / 6;
            ph     = pos % 6;
            exp_an = 4'hF;
            exp_sv = 7'h7F;
            if (ph < 4) begin
                nib   = shown[4*d +: 4];
                blank = lz && (d > 0) && ((shown >> (4*d)) == 16'h0000);
                if (!blank) begin
                    exp_an = ~(4'b0001 << d);
                    exp_sv = glyph(nib);
                end
            end
            chk($sformatf("%s.c%0d.anodo", name, j), anodo, exp_an);
            chk($sformatf("%s.c%0d.seven", name, j), seven, exp_sv);
            chk($sformatf("%s.c%0d.pending", name, j), pending_o, m_pend);
            chk($sformatf("%s.c%0d.frame", name, j), frame_o, (j == 24));
            loaded = 1'b0;
            load_i = 1'b0;
            if (j == la || j == lb || j == lc) begin
                lval   = (j == la) ? va : ((j == lb) ? vb : vc);
                data_i = lval;
                load_i = 1'b1;
                loaded = 1'b1;
            end
        end
        load_i = 1'b0;
    endtask

    task automatic boot_after_reset(input string name);
        m_disp  = '0;
        m_stage = '0;
        m_pend  = 1'b0;
        @(negedge clk);
        chk({name, ".e1.frame"}, frame_o, 1'b0);
        chk({name, ".e1.anodo"}, anodo, 4'hF);
        @(negedge clk);
        chk({name, ".e2.frame"}, frame_o, 1'b1);
        chk({name, ".e2.pending"}, pending_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        load_i     = 1'b0;
        data_i     = '0;
        blank_lz_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.anodo",   anodo,     4'hF);
        chk("rst.seven",   seven,     7'h7F);
        chk("rst.pending", pending_o, 1'b0);
        chk("rst.frame",   frame_o,   1'b0);
        rst = 1'b0;
        boot_after_reset("boot");

        run_frame("idle",     1'b0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        run_frame("ld1a3d",   1'b0, 10, 16'h1A3D, 0, 16'h0, 0, 16'h0);
        run_frame("show1a3d", 1'b0, 3, 16'h1111, 15, 16'h2222, 23, 16'h3333);
        run_frame("show2222", 1'b0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        run_frame("show3333", 1'b0, 5, 16'h00E5, 0, 16'h0, 0, 16'h0);
        run_frame("lz00e5",   1'b1, 0, 16'h0, 0, 16'h0, 0, 16'h0);

        // Mid-frame reset during digit 2 drive with staged data waiting.
        blank_lz_i = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            load_i = (j == 2);
            if (j == 2) data_i = 16'h9999;
        end
        chk("prerst.anodo",   anodo,     4'b1011);
        chk("prerst.pending", pending_o, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("midrst.anodo",   anodo,     4'hF);
        chk("midrst.seven",   seven,     7'h7F);
        chk("midrst.pending", pending_o, 1'b0);
        chk("midrst.frame",   frame_o,   1'b0);
        @(negedge clk);
        rst = 1'b0;
        boot_after_reset("reboot");
        run_frame("postrst", 1'b0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        run_frame("lz0000",  1'b1, 0, 16'h0, 0, 16'h0, 0, 16'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
